// File: rtl/me_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, EX bus field
// positions, FSM state encodings and the load-alignment exception helper.
package me_stage_pkg;

  localparam int EX_BUS_W  = 125;
  localparam int WB_BUS_W  = 120;
  localparam int FWD_BUS_W = 47;

  // Least-significant bit of each field on the incoming EX bus
  localparam int EX_CSR_NUM_LSB    = 111;
  localparam int EX_CSR_WE_BIT     = 110;
  localparam int EX_CSR_WVALUE_LSB = 78;
  localparam int EX_SYSCALL_BIT    = 77;
  localparam int EX_ERTN_BIT       = 76;
  localparam int EX_SIGNED_BIT     = 75;
  localparam int EX_BYTE_BIT       = 74;
  localparam int EX_HALF_BIT       = 73;
  localparam int EX_OFFSET_LSB     = 71;
  localparam int EX_PC_LSB         = 39;
  localparam int EX_RESULT_LSB     = 7;
  localparam int EX_FROM_MEM_BIT   = 6;
  localparam int EX_GR_WE_BIT      = 5;
  localparam int EX_DEST_LSB       = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } me_state_t;

  // A halfword needs an even address, a word needs a word-aligned address
  function automatic logic misaligned(input logic is_byte, input logic is_half,
                                      input logic [1:0] offset);
    if (is_byte) return 1'b0;
    if (is_half) return offset[0];
    return offset != 2'b00;
  endfunction

endpackage

// File: rtl/me_stage_load_align.sv
// Load data alignment: picks the addressed byte or halfword out of the
// SRAM read word and sign- or zero-extends it to 32 bits.
module me_stage_load_align
  import me_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic        i_is_byte,
  input  logic        i_is_half,
  input  logic        i_is_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Select the addressed byte lane, then extend according to access size
  always_comb begin
    w_byte = i_rdata[7:0];
    o_data = i_rdata;
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    if (i_is_byte) begin
      o_data = {{24{i_is_signed & w_byte[7]}}, w_byte};
    end else if (i_is_half) begin
      o_data = {{16{i_is_signed & w_half[15]}}, w_half};
    end
  end

endmodule

// File: rtl/me_stage.sv
// Memory-access pipeline stage: holds one EX bundle, waits for the data
// SRAM read response on loads, aligns load data and hands the bundle to WB.
// A flush cancels the bundle; a load response still in flight after a flush
// is swallowed in the DRAIN state so it cannot be mistaken for a later load.
// Optional build macro ME_ALIGN_EXCP_EN: misaligned loads raise excp_ale,
// skip the SRAM wait and have their register/CSR writes suppressed.
module me_stage
  import me_stage_pkg::*;
#(
  parameter int EX_TO_ME_W = EX_BUS_W,
  parameter int ME_TO_WB_W = WB_BUS_W,
  parameter int ME_TO_EX_W = FWD_BUS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_to_ME_Valid,
  input  logic [EX_TO_ME_W-1:0] EX_to_ME_Bus,
  output logic                  ME_Allow_in,
  input  logic                  data_sram_rvalid,
  input  logic [31:0]           data_sram_rdata,
  output logic                  ME_to_WB_Valid,
  input  logic                  WB_Allow_in,
  output logic [ME_TO_WB_W-1:0] ME_to_WB_Bus,
  output logic [4:0]            ME_dest,
  output logic [31:0]           ME_Forward_Res,
  output logic                  ME_to_ID_Ld_op,
  output logic                  ME_to_ID_Sys_op,
  output logic [ME_TO_EX_W-1:0] ME_to_EX_Bus,
  input  logic                  excp_flush,
  input  logic                  ertn_flush
);

  logic                  r_valid;
  logic [EX_TO_ME_W-1:0] r_bus;
  me_state_t             r_state;
  me_state_t             w_state_next;
  logic [31:0]           r_buf;

  logic [13:0] w_csr_num;
  logic        w_csr_we;
  logic [31:0] w_csr_wvalue;
  logic        w_syscall;
  logic        w_ertn;
  logic        w_is_signed;
  logic        w_is_byte;
  logic        w_is_half;
  logic [1:0]  w_offset;
  logic [31:0] w_pc;
  logic [31:0] w_result;
  logic        w_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;

  logic        w_flush;
  logic        w_ale;
  logic        w_in_ale;
  logic        w_waiting_load;
  logic        w_ready_go;
  logic        w_accept;
  logic        w_accept_load;
  logic [31:0] w_mem_data;
  logic [31:0] w_load_data;
  logic [31:0] w_final;
  logic        w_gr_we_eff;
  logic        w_csr_we_eff;

  assign w_csr_num    = r_bus[EX_CSR_NUM_LSB +: 14];
  assign w_csr_we     = r_bus[EX_CSR_WE_BIT];
  assign w_csr_wvalue = r_bus[EX_CSR_WVALUE_LSB +: 32];
  assign w_syscall    = r_bus[EX_SYSCALL_BIT];
  assign w_ertn       = r_bus[EX_ERTN_BIT];
  assign w_is_signed  = r_bus[EX_SIGNED_BIT];
  assign w_is_byte    = r_bus[EX_BYTE_BIT];
  assign w_is_half    = r_bus[EX_HALF_BIT];
  assign w_offset     = r_bus[EX_OFFSET_LSB +: 2];
  assign w_pc         = r_bus[EX_PC_LSB +: 32];
  assign w_result     = r_bus[EX_RESULT_LSB +: 32];
  assign w_from_mem   = r_bus[EX_FROM_MEM_BIT];
  assign w_gr_we      = r_bus[EX_GR_WE_BIT];
  assign w_dest       = r_bus[EX_DEST_LSB +: 5];

  assign w_flush = excp_flush | ertn_flush;

`ifdef ME_ALIGN_EXCP_EN
  assign w_ale    = w_from_mem & misaligned(w_is_byte, w_is_half, w_offset);
  assign w_in_ale = EX_to_ME_Bus[EX_FROM_MEM_BIT] &
                    misaligned(EX_to_ME_Bus[EX_BYTE_BIT], EX_to_ME_Bus[EX_HALF_BIT],
                               EX_to_ME_Bus[EX_OFFSET_LSB +: 2]);
`else
  assign w_ale    = 1'b0;
  assign w_in_ale = 1'b0;
`endif

  // A load raising an alignment exception never issued a read, so it is
  // not waiting for anything
  assign w_waiting_load = w_from_mem & ~w_ale;
  assign w_ready_go     = ~w_waiting_load | (r_state == S_HOLD) |
                          ((r_state == S_WAIT) & data_sram_rvalid);

  assign ME_Allow_in   = (r_state != S_DRAIN) & (~r_valid | (w_ready_go & WB_Allow_in));
  assign w_accept      = ME_Allow_in & EX_to_ME_Valid & ~w_flush;
  assign w_accept_load = w_accept & EX_to_ME_Bus[EX_FROM_MEM_BIT] & ~w_in_ale;

  assign w_mem_data = (r_state == S_HOLD) ? r_buf : data_sram_rdata;

  me_stage_load_align u_load_align (
    .i_rdata     (w_mem_data),
    .i_offset    (w_offset),
    .i_is_byte   (w_is_byte),
    .i_is_half   (w_is_half),
    .i_is_signed (w_is_signed),
    .o_data      (w_load_data)
  );

  assign w_final      = w_from_mem ? w_load_data : w_result;
  assign w_gr_we_eff  = w_gr_we & ~w_ale;
  assign w_csr_we_eff = w_csr_we & ~w_ale;

  assign ME_to_WB_Valid  = r_valid & w_ready_go & ~w_flush;
  assign ME_to_WB_Bus    = {w_csr_num, w_csr_we_eff, w_csr_wvalue, w_syscall, w_ertn,
                            w_ale, w_pc, w_final, w_gr_we_eff, w_dest};
  assign ME_dest         = w_dest & {5{r_valid & w_gr_we_eff}};
  assign ME_Forward_Res  = w_final;
  assign ME_to_ID_Ld_op  = r_valid & w_waiting_load & ~w_ready_go;
  assign ME_to_ID_Sys_op = r_valid & (w_syscall | w_ertn);
  assign ME_to_EX_Bus    = {w_csr_num, w_csr_we_eff & r_valid, w_csr_wvalue};

  // Stage occupancy and bundle register; a flush wins over acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else begin
      if (w_flush) begin
        r_valid <= 1'b0;
      end else if (ME_Allow_in) begin
        r_valid <= EX_to_ME_Valid;
      end
      if (w_accept) begin
        r_bus <= EX_to_ME_Bus;
      end
    end
  end

  // Keep the read response when WB stalls on the cycle it arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= '0;
    end else if ((r_state == S_WAIT) && data_sram_rvalid && !WB_Allow_in && !w_flush) begin
      r_buf <= data_sram_rdata;
    end
  end

  // Load-response tracking state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a flushed load with its response still outstanding drains
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_load) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_flush) begin
          w_state_next = data_sram_rvalid ? S_IDLE : S_DRAIN;
        end else if (data_sram_rvalid) begin
          if (WB_Allow_in) w_state_next = w_accept_load ? S_WAIT : S_IDLE;
          else             w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_flush)          w_state_next = S_IDLE;
        else if (WB_Allow_in) w_state_next = w_accept_load ? S_WAIT : S_IDLE;
      end
      S_DRAIN: begin
        if (data_sram_rvalid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_me_stage.sv
// Randomized self-checking bench for me_stage. A transaction-level model
// tracks which bundle occupies the stage, whether its load data has arrived
// and whether a flushed load response is still due from the SRAM.
module tb_me_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         EX_to_ME_Valid;
  logic [124:0] EX_to_ME_Bus;
  logic         ME_Allow_in;
  logic         data_sram_rvalid;
  logic [31:0]  data_sram_rdata;
  logic         ME_to_WB_Valid;
  logic         WB_Allow_in;
  logic [119:0] ME_to_WB_Bus;
  logic [4:0]   ME_dest;
  logic [31:0]  ME_Forward_Res;
  logic         ME_to_ID_Ld_op;
  logic         ME_to_ID_Sys_op;
  logic [46:0]  ME_to_EX_Bus;
  logic         excp_flush;
  logic         ertn_flush;

  me_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EX_to_ME_Valid   (EX_to_ME_Valid),
    .EX_to_ME_Bus     (EX_to_ME_Bus),
    .ME_Allow_in      (ME_Allow_in),
    .data_sram_rvalid (data_sram_rvalid),
    .data_sram_rdata  (data_sram_rdata),
    .ME_to_WB_Valid   (ME_to_WB_Valid),
    .WB_Allow_in      (WB_Allow_in),
    .ME_to_WB_Bus     (ME_to_WB_Bus),
    .ME_dest          (ME_dest),
    .ME_Forward_Res   (ME_Forward_Res),
    .ME_to_ID_Ld_op   (ME_to_ID_Ld_op),
    .ME_to_ID_Sys_op  (ME_to_ID_Sys_op),
    .ME_to_EX_Bus     (ME_to_EX_Bus),
    .excp_flush       (excp_flush),
    .ertn_flush       (ertn_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] csrNum;
    logic        csrWe;
    logic [31:0] csrWvalue;
    logic        syscall;
    logic        ertn;
    logic        isSigned;
    logic        isByte;
    logic        isHalf;
    logic [1:0]  offset;
    logic [31:0] pc;
    logic [31:0] result;
    logic        fromMem;
    logic        grWe;
    logic [4:0]  dest;
  } bundle_t;

  int total = 0;
  int bad   = 0;

  bundle_t     exBundle;
  bundle_t     meItem;
  logic [31:0] meData;
  bit          haveItem;
  bit          meGotData;
  bit          drainPending;
  bit          exAccepted;
  int          respCnt;
  logic [31:0] respData;
  bit          drainPhase;

  bit          readyGoExp;
  bit          allowExp;
  bit          flushNow;
  bit          wbValidExp;

  // Counts every comparison and reports a mismatch with both values
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic isAle(input bundle_t b);
`ifdef ME_ALIGN_EXCP_EN
    if (!b.fromMem || b.isByte) return 1'b0;
    if (b.isHalf) return b.offset[0];
    return b.offset != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic isWaitingLoad(input bundle_t b);
    return b.fromMem && !isAle(b);
  endfunction

  // Load value from the architectural rules using shifts and masks
  function automatic logic [31:0] finalResult(input bundle_t b, input logic [31:0] raw);
    logic [31:0] v;
    if (!b.fromMem) return b.result;
    if (b.isByte) begin
      v = (raw >> (8 * b.offset)) & 32'hFF;
      if (b.isSigned && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (b.isHalf) begin
      v = (raw >> (16 * b.offset[1])) & 32'hFFFF;
      if (b.isSigned && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  function automatic logic [124:0] packBundle(input bundle_t b);
    return {b.csrNum, b.csrWe, b.csrWvalue, b.syscall, b.ertn, b.isSigned, b.isByte,
            b.isHalf, b.offset, b.pc, b.result, b.fromMem, b.grWe, b.dest};
  endfunction

  function automatic logic [119:0] expWbBus(input bundle_t b, input logic [31:0] raw);
    logic ale;
    ale = isAle(b);
    return {b.csrNum, b.csrWe & ~ale, b.csrWvalue, b.syscall, b.ertn, ale, b.pc,
            finalResult(b, raw), b.grWe & ~ale, b.dest};
  endfunction

  function automatic bundle_t randomBundle();
    bundle_t b;
    int size;
    size        = int'($urandom_range(0, 2));
    b.csrNum    = 14'($urandom);
    b.csrWe     = 1'($urandom_range(0, 1));
    b.csrWvalue = $urandom;
    b.syscall   = ($urandom_range(0, 9) == 0);
    b.ertn      = ($urandom_range(0, 9) == 0);
    b.isSigned  = 1'($urandom_range(0, 1));
    b.isByte    = (size == 0);
    b.isHalf    = (size == 1);
    b.offset    = 2'($urandom_range(0, 3));
    b.pc        = $urandom;
    b.result    = $urandom;
    b.fromMem   = 1'($urandom_range(0, 1));
    b.grWe      = 1'($urandom_range(0, 1));
    b.dest      = 5'($urandom);
    return b;
  endfunction

  // Drives one cycle of EX, WB, flush and SRAM response inputs
  task automatic applyStimulus();
    if (!EX_to_ME_Valid || exAccepted) begin
      exBundle       = randomBundle();
      EX_to_ME_Valid = !drainPhase && ($urandom_range(0, 99) < 70);
      EX_to_ME_Bus   = packBundle(exBundle);
    end
    WB_Allow_in = drainPhase || ($urandom_range(0, 99) < 65);
    excp_flush  = 1'b0;
    ertn_flush  = 1'b0;
    if (!drainPhase && $urandom_range(0, 11) == 0) begin
      if ($urandom_range(0, 1) == 1) excp_flush = 1'b1;
      else                           ertn_flush = 1'b1;
    end
    data_sram_rvalid = 1'b0;
    data_sram_rdata  = $urandom;
    if (respCnt > 0) begin
      respCnt--;
      if (respCnt == 0) begin
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = respData;
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    EX_to_ME_Valid   = 1'b0;
    EX_to_ME_Bus     = '0;
    WB_Allow_in      = 1'b0;
    excp_flush       = 1'b0;
    ertn_flush       = 1'b0;
    data_sram_rvalid = 1'b0;
    data_sram_rdata  = '0;
    haveItem         = 1'b0;
    meGotData        = 1'b0;
    drainPending     = 1'b0;
    exAccepted       = 1'b0;
    respCnt          = 0;
    respData         = '0;
    meData           = '0;
    drainPhase       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetWbValid", ME_to_WB_Valid, 1'b0);
    checkOutput("resetAllowIn", ME_Allow_in, 1'b1);
    checkOutput("resetDest", ME_dest, 5'd0);
    checkOutput("resetLdOp", ME_to_ID_Ld_op, 1'b0);
    checkOutput("resetSysOp", ME_to_ID_Sys_op, 1'b0);
    checkOutput("resetExCsrWe", ME_to_EX_Bus[32], 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      drainPhase = (cyc >= 1560);
      applyStimulus();

      @(negedge clk);
      readyGoExp = !haveItem || !isWaitingLoad(meItem) || meGotData || data_sram_rvalid;
      allowExp   = !drainPending && (!haveItem || (readyGoExp && WB_Allow_in));
      flushNow   = excp_flush || ertn_flush;
      wbValidExp = haveItem && readyGoExp && !flushNow;

      checkOutput("allowIn", ME_Allow_in, allowExp);
      checkOutput("wbValid", ME_to_WB_Valid, wbValidExp);
      if (wbValidExp)
        checkOutput("wbBus", ME_to_WB_Bus, expWbBus(meItem, meData));
      checkOutput("meDest", ME_dest,
                  (haveItem && meItem.grWe && !isAle(meItem)) ? meItem.dest : 5'd0);
      checkOutput("ldOp", ME_to_ID_Ld_op, haveItem && isWaitingLoad(meItem) && !readyGoExp);
      checkOutput("sysOp", ME_to_ID_Sys_op, haveItem && (meItem.syscall || meItem.ertn));
      checkOutput("exCsrWe", ME_to_EX_Bus[32], haveItem && meItem.csrWe && !isAle(meItem));
      if (haveItem) begin
        checkOutput("exCsrFields", {ME_to_EX_Bus[46:33], ME_to_EX_Bus[31:0]},
                    {meItem.csrNum, meItem.csrWvalue});
        if (readyGoExp)
          checkOutput("fwdRes", ME_Forward_Res, finalResult(meItem, meData));
      end

      @(posedge clk);
      if (data_sram_rvalid) begin
        if (drainPending)  drainPending = 1'b0;
        else if (haveItem) meGotData = 1'b1;
      end
      exAccepted = 1'b0;
      if (flushNow) begin
        if (haveItem && isWaitingLoad(meItem) && !meGotData) drainPending = 1'b1;
        haveItem = 1'b0;
      end else begin
        if (haveItem && readyGoExp && WB_Allow_in) haveItem = 1'b0;
        if (allowExp && EX_to_ME_Valid) begin
          haveItem   = 1'b1;
          meItem     = exBundle;
          meGotData  = 1'b0;
          exAccepted = 1'b1;
          if (isWaitingLoad(exBundle)) begin
            respCnt  = int'($urandom_range(1, 3));
            respData = $urandom;
            meData   = respData;
          end
        end
      end
      #1;
    end

    checkOutput("endIdleWbValid", ME_to_WB_Valid, 1'b0);
    checkOutput("endIdleAllowIn", ME_Allow_in, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the LoongArch pipeline.
- Consumes the EX-to-ME bus and waits for the data-SRAM read response on loads.
- Aligns and extends load data, then forwards results and CSR writes to ID and EX.
- Hands a completed bundle to WB with a valid/allow-in handshake; exception and ertn flushes cancel it, and an in-flight load response is drained safely.

Parameters:
- EX_TO_ME_W, 125, width of incoming EX bus.
- ME_TO_WB_W, 120, width of outgoing WB bus.
- ME_TO_EX_W, 47, width of CSR forwarding bus to EX.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- EX_to_ME_Valid  in  1  EX bundle valid
- EX_to_ME_Bus  in  EX_TO_ME_W  {csr_num[124:111], csr_we[110], csr_wvalue[109:78], syscall[77], ertn[76], src_is_signed[75], mem_is_byte[74], mem_is_half[73], offset[72:71], pc[70:39], result[38:7], res_from_mem[6], gr_we[5], dest[4:0]}
- ME_Allow_in  out  1  ME can accept a bundle this cycle
- data_sram_rvalid  in  1  read response valid (1+ cycles after EX request)
- data_sram_rdata  in  32  read response data
- ME_to_WB_Valid  out  1  bundle to WB valid
- WB_Allow_in  in  1  WB can accept
- ME_to_WB_Bus  out  ME_TO_WB_W  {csr_num[119:106], csr_we[105], csr_wvalue[104:73], syscall[72], ertn[71], excp_ale[70], pc[69:38], final_result[37:6], gr_we[5], dest[4:0]}
- ME_dest  out  5  dest & valid & gr_we, for ID hazard check
- ME_Forward_Res  out  32  final_result
- ME_to_ID_Ld_op  out  1  valid load whose data is not yet available
- ME_to_ID_Sys_op  out  1  valid syscall or ertn in ME
- ME_to_EX_Bus  out  ME_TO_EX_W  {csr_num, csr_we & ME_Valid, csr_wvalue}
- excp_flush  in  1  exception flush
- ertn_flush  in  1  ertn flush

Behaviour:
- Reset values: ME_Valid=0; state=IDLE; all valid-qualified outputs 0; data buffer 0.
- Latch: on ME_Allow_in && EX_to_ME_Valid, register the bus and set ME_Valid=1.
- ME_Allow_in = !DRAIN && (!ME_Valid || (ready_go && WB_Allow_in)).
- ME_to_WB_Valid = ME_Valid && ready_go && !flush.
- ready_go = !res_from_mem || state==HOLD || (state==WAIT && data_sram_rvalid).
- FSM states:
  - IDLE: accepting a load goes to WAIT.
  - WAIT: on rvalid && WB_Allow_in, go to IDLE (or to WAIT if a new load is accepted the same cycle). On rvalid && !WB_Allow_in, capture rdata and go to HOLD.
  - HOLD: output the buffered data; on WB_Allow_in, go to IDLE/WAIT as above.
  - DRAIN: discard the next rvalid, then go to IDLE.
- Flush (excp_flush|ertn_flush):
  - ME_Valid=0 next cycle.
  - WAIT without rvalid that cycle → DRAIN; WAIT with rvalid the same cycle → IDLE.
  - HOLD → IDLE.
  - Flush has priority over acceptance.
- Reset mid-operation: immediately IDLE, no drain; the SRAM is reset alongside.
- Load data:
  - byte: rdata byte selected by offset.
  - half: rdata[15:0] if offset[1]=0, else rdata[31:16].
  - word: rdata.
  - sign-extend if src_is_signed, else zero-extend.
  - final_result = res_from_mem ? load_data : result.
- Non-load bundles pass through in 0 extra cycles (ready_go=1).

Optional Feature:
- Macro ME_ALIGN_EXCP_EN.
- Defined:
  - excp_ale=1 for a load when half with offset[0]=1, or word with offset!=0.
  - Such a load does not wait for rvalid (ready_go=1, no WAIT).
  - Its gr_we and csr_we are forced to 0 on the WB bus.
  - EX guarantees no SRAM read is issued for it.
- Undefined: excp_ale tied 0; misaligned offsets use the selection rules above.

Decomposition:
- Shared package/header: bus width constants, bus field offsets, and FSM state encodings (IDLE=0, WAIT=1, HOLD=2, DRAIN=3).
- One sub-module, load_align: combinational byte/half select and extension.

Test Plan:
- ALU bundle result=0x1234, dest=5, WB_Allow_in=1 → WB valid next cycle, final_result=0x1234, ME_dest=5.
- ld.b signed, offset=2, rdata=0x00800000, rvalid 2 cycles late → ME_to_ID_Ld_op=1 while waiting; WB gets 0xFFFFFF80.
- ld.hu, offset=2, rdata=0xBEEF0000, WB_Allow_in=0 for 3 cycles → HOLD retains data; WB gets 0x0000BEEF.
- excp_flush in WAIT, rvalid one cycle later with a new load pending → DRAIN discards it; ME_Allow_in=0 during DRAIN; the next load gets its own rdata.
- csr_we=1, csr_num=0x6, wvalue=0x55 → ME_to_EX_Bus carries {0x6, 1, 0x55}; after the bundle leaves ME, csr_we field is 0.
- With ME_ALIGN_EXCP_EN: ld.w, offset=1 → excp_ale=1, gr_we=0, WB valid after 1 cycle with no rvalid.
